// File: rtl/ps2_keymap.sv
// PS/2 scan code set 2 to ASCII translator with modifier tracking and Pause skipping.
// Optional PS2_KEYMAP_ANSI_EN: arrow keys emit ESC '[' X sequences, extended delete emits 0x7F.
module ps2_keymap #(
  parameter bit CAPS_INIT  = 1'b0,
  parameter int PAUSE_SKIP = 7
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic [7:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [7:0] kb_data,
  output logic       kb_valid,
  input  logic       kb_ready,
  output logic [2:0] mods
);

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, SKIP} state_t;

  state_t     state_reg;
  logic [7:0] skip_reg;
  logic       lshift_reg, rshift_reg, lctrl_reg, rctrl_reg, caps_reg, caps_held_reg;
  logic [7:0] kb_data_reg;
  logic       kb_valid_reg;
  logic       esc_pending;
  logic       shift, ctrl, sym_fire, kb_fire;
  logic [7:0] letter, make_char;

`ifdef PS2_KEYMAP_ANSI_EN
  logic [1:0] esc_cnt_reg;
  logic [7:0] esc_char_reg;
  assign esc_pending = (esc_cnt_reg != 2'd0);
`else
  assign esc_pending = 1'b0;
`endif

  function automatic logic [7:0] letter_of(input logic [7:0] code);
    logic [7:0] c;
    c = 8'h00;
    case (code)
      8'h1C: c = "a"; 8'h32: c = "b"; 8'h21: c = "c"; 8'h23: c = "d";
      8'h24: c = "e"; 8'h2B: c = "f"; 8'h34: c = "g"; 8'h33: c = "h";
      8'h43: c = "i"; 8'h3B: c = "j"; 8'h42: c = "k"; 8'h4B: c = "l";
      8'h3A: c = "m"; 8'h31: c = "n"; 8'h44: c = "o"; 8'h4D: c = "p";
      8'h15: c = "q"; 8'h2D: c = "r"; 8'h1B: c = "s"; 8'h2C: c = "t";
      8'h3C: c = "u"; 8'h2A: c = "v"; 8'h1D: c = "w"; 8'h22: c = "x";
      8'h35: c = "y"; 8'h1A: c = "z";
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Non-letter keys: {unshifted, shifted} glyph pair, zero when unmapped.
  function automatic logic [7:0] glyph_of(input logic [7:0] code, input logic sh);
    logic [15:0] p;
    p = 16'h0000;
    case (code)
      8'h16: p = {"1", "!"};  8'h1E: p = {"2", "@"};  8'h26: p = {"3", "#"};
      8'h25: p = {"4", "$"};  8'h2E: p = {"5", "%"};  8'h36: p = {"6", "^"};
      8'h3D: p = {"7", "&"};  8'h3E: p = {"8", "*"};  8'h46: p = {"9", "("};
      8'h45: p = {"0", ")"};  8'h0E: p = {8'h60, "~"}; 8'h4E: p = {"-", "_"};
      8'h55: p = {"=", "+"};  8'h54: p = {"[", "{"};  8'h5B: p = {"]", "}"};
      8'h5D: p = {"\\", "|"}; 8'h4C: p = {";", ":"};  8'h52: p = {"'", "\""};
      8'h41: p = {",", "<"};  8'h49: p = {".", ">"};  8'h4A: p = {"/", "?"};
      8'h29: p = 16'h2020;    8'h5A: p = 16'h0D0D;    8'h66: p = 16'h0808;
      8'h0D: p = 16'h0909;    8'h76: p = 16'h1B1B;
      default: p = 16'h0000;
    endcase
    return sh ? p[7:0] : p[15:8];
  endfunction

  assign shift     = lshift_reg | rshift_reg;
  assign ctrl      = lctrl_reg | rctrl_reg;
  assign mods      = {caps_reg, ctrl, shift};
  assign sym_ready = !rst && !kb_valid_reg && !esc_pending;
  assign sym_fire  = sym_valid && sym_ready;
  assign kb_fire   = kb_valid_reg && kb_ready;
  assign kb_data   = kb_data_reg;
  assign kb_valid  = kb_valid_reg;

  always_comb begin
    letter    = letter_of(sym_data);
    make_char = glyph_of(sym_data, shift);
    if (letter != 8'h00) begin
      if (ctrl)                 make_char = letter & 8'h1F;
      else if (shift ^ caps_reg) make_char = letter - 8'h20;
      else                      make_char = letter;
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state_reg     <= IDLE;
      skip_reg      <= 8'h00;
      lshift_reg    <= 1'b0;
      rshift_reg    <= 1'b0;
      lctrl_reg     <= 1'b0;
      rctrl_reg     <= 1'b0;
      caps_reg      <= CAPS_INIT;
      caps_held_reg <= 1'b0;
      kb_data_reg   <= 8'h00;
      kb_valid_reg  <= 1'b0;
`ifdef PS2_KEYMAP_ANSI_EN
      esc_cnt_reg   <= 2'd0;
      esc_char_reg  <= 8'h00;
`endif
    end else begin
      if (kb_fire) begin
`ifdef PS2_KEYMAP_ANSI_EN
        // Remaining escape bytes go out back-to-back without dropping kb_valid.
        if (esc_cnt_reg == 2'd2) begin
          kb_data_reg <= 8'h5B;
          esc_cnt_reg <= 2'd1;
        end else if (esc_cnt_reg == 2'd1) begin
          kb_data_reg <= esc_char_reg;
          esc_cnt_reg <= 2'd0;
        end else begin
          kb_valid_reg <= 1'b0;
        end
`else
        kb_valid_reg <= 1'b0;
`endif
      end
      if (sym_fire) begin
        case (state_reg)
          IDLE: begin
            case (sym_data)
              8'hF0: state_reg <= BRK;
              8'hE0: state_reg <= EXT;
              8'hE1: begin
                state_reg <= SKIP;
                skip_reg  <= 8'(PAUSE_SKIP);
              end
              8'h12: lshift_reg <= 1'b1;
              8'h59: rshift_reg <= 1'b1;
              8'h14: lctrl_reg  <= 1'b1;
              8'h58: begin
                // Typematic repeats of caps must not re-toggle.
                if (!caps_held_reg) caps_reg <= !caps_reg;
                caps_held_reg <= 1'b1;
              end
              default: begin
                if (make_char != 8'h00) begin
                  kb_data_reg  <= make_char;
                  kb_valid_reg <= 1'b1;
                end
              end
            endcase
          end
          BRK: begin
            case (sym_data)
              8'h12:   lshift_reg    <= 1'b0;
              8'h59:   rshift_reg    <= 1'b0;
              8'h14:   lctrl_reg     <= 1'b0;
              8'h58:   caps_held_reg <= 1'b0;
              default: ;
            endcase
            state_reg <= IDLE;
          end
          EXT: begin
            state_reg <= IDLE;
            if (sym_data == 8'hF0) begin
              state_reg <= EXT_BRK;
            end else if (sym_data == 8'h14) begin
              rctrl_reg <= 1'b1;
            end
`ifdef PS2_KEYMAP_ANSI_EN
            else begin
              case (sym_data)
                8'h75, 8'h72, 8'h74, 8'h6B: begin
                  kb_data_reg  <= 8'h1B;
                  kb_valid_reg <= 1'b1;
                  esc_cnt_reg  <= 2'd2;
                  esc_char_reg <= (sym_data == 8'h75) ? "A" :
                                  (sym_data == 8'h72) ? "B" :
                                  (sym_data == 8'h74) ? "C" : "D";
                end
                8'h71: begin
                  kb_data_reg  <= 8'h7F;
                  kb_valid_reg <= 1'b1;
                end
                default: ;
              endcase
            end
`endif
          end
          EXT_BRK: begin
            if (sym_data == 8'h14) rctrl_reg <= 1'b0;
            state_reg <= IDLE;
          end
          SKIP: begin
            skip_reg <= skip_reg - 8'd1;
            if (skip_reg <= 8'd1) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
